// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
//   Round-robin write arbiter that shares one FIFO write port among NUM_REQ
//   producers. A grant is taken in IDLE (one-cycle arbitration, no beat in
//   the grant cycle) and held in BURST until a beat carries req_last or the
//   MAX_BURST-th beat is written. The grant then returns to IDLE, and the
//   round-robin pointer moves past the releasing requester.
//
//   Optional feature (macro ARB_IDLE_RELEASE_EN): a held grant is released
//   after IDLE_LIMIT consecutive BURST cycles in which the granted requester
//   does not assert req_wr_en.
//
// Ports
//   clk            clock, rising edge
//   reset          asynchronous reset, active low
//   req_wr_en      per-requester write valid
//   req_wr_data    packed per-requester data, slot i at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_last       per-requester final-beat marker (sampled on beats only)
//   req_wr_ready   per-requester accept (only the granted bit can be 1)
//   fifo_wr_en     write strobe to the FIFO
//   fifo_wr_data   write data to the FIFO
//   fifo_wr_ready  FIFO not full
//   grant_valid    a grant is held (state BURST)
//   grant_idx      index of the granted requester
module fifo_wr_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 4,
  parameter int MAX_BURST  = 4,
  parameter int IDLE_LIMIT = 4,
  parameter int IDX_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_wr_en,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wr_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_wr_ready,
  output logic                          fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         fifo_wr_data,
  input  logic                          fifo_wr_ready,
  output logic                          grant_valid,
  output logic [IDX_W-1:0]              grant_idx
);

  localparam int CNT_W = $clog2(MAX_BURST) + 1;
  localparam logic [CNT_W-1:0] BEAT_LAST = CNT_W'(MAX_BURST - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_REQ - 1);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_BURST = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0] grant_idx_q, grant_idx_d;
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;

  // Signals of the currently granted requester
  logic                  sel_en;
  logic                  sel_last;
  logic [DATA_WIDTH-1:0] sel_data;

  logic                  pick_found;
  logic [IDX_W-1:0]      pick_idx;
  logic                  idle_release;

  // Granted-requester select. grant_idx_q never exceeds NUM_REQ-1, so one
  // slot always matches.
  always_comb begin
    sel_en   = 1'b0;
    sel_last = 1'b0;
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_idx_q == IDX_W'(i)) begin
        sel_en   = req_wr_en[i];
        sel_last = req_last[i];
        sel_data = req_wr_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Round-robin search starting at rr_ptr and wrapping mod NUM_REQ; the
  // first set request bit met along that order wins.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!pick_found && req_wr_en[(int'(rr_ptr_q) + k) % NUM_REQ]) begin
        pick_found = 1'b1;
        pick_idx   = IDX_W'((int'(rr_ptr_q) + k) % NUM_REQ);
      end
    end
  end

`ifdef ARB_IDLE_RELEASE_EN
  localparam int IDLE_W = $clog2(IDLE_LIMIT + 1);

  logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;

  // Counts consecutive BURST cycles without a request from the grantee;
  // the cycle that would bring it to IDLE_LIMIT releases the grant.
  always_comb begin
    idle_cnt_d   = idle_cnt_q;
    idle_release = 1'b0;
    if (state_q == S_IDLE || sel_en) begin
      idle_cnt_d = '0;
    end else if (idle_cnt_q == IDLE_W'(IDLE_LIMIT - 1)) begin
      idle_release = 1'b1;
      idle_cnt_d   = '0;
    end else begin
      idle_cnt_d = idle_cnt_q + IDLE_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idle_cnt_q <= '0;
    end else begin
      idle_cnt_q <= idle_cnt_d;
    end
  end
`else
  // Keeps IDLE_LIMIT referenced when the idle release is compiled out.
  logic unused_idle_limit;
  assign unused_idle_limit = (IDLE_LIMIT > 0);
  assign idle_release      = 1'b0;
`endif

  // Next state and the combinational write path
  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    grant_idx_d  = grant_idx_q;
    beat_cnt_d   = beat_cnt_q;
    fifo_wr_en   = 1'b0;
    fifo_wr_data = '0;
    req_wr_ready = '0;

    case (state_q)
      S_IDLE: begin
        if (pick_found) begin
          grant_idx_d = pick_idx;
          beat_cnt_d  = '0;
          state_d     = S_BURST;
        end
      end

      S_BURST: begin
        fifo_wr_en   = sel_en;
        fifo_wr_data = sel_data;
        for (int i = 0; i < NUM_REQ; i++) begin
          req_wr_ready[i] = fifo_wr_ready && (grant_idx_q == IDX_W'(i));
        end

        if ((sel_en && fifo_wr_ready && (sel_last || beat_cnt_q == BEAT_LAST)) ||
            idle_release) begin
          // Releasing requester becomes lowest priority next arbitration.
          state_d    = S_IDLE;
          beat_cnt_d = '0;
          rr_ptr_d   = (grant_idx_q == IDX_LAST) ? '0 : grant_idx_q + IDX_W'(1);
        end else if (sel_en && fifo_wr_ready) begin
          beat_cnt_d = beat_cnt_q + CNT_W'(1);
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      rr_ptr_q    <= '0;
      grant_idx_q <= '0;
      beat_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_idx_q <= grant_idx_d;
      beat_cnt_q  <= beat_cnt_d;
    end
  end

  assign grant_valid = (state_q == S_BURST);
  assign grant_idx   = grant_idx_q;

endmodule
